control_pipe: RTL and testbench

Registered, parametrised main decoder for the PSRV32 pipeline, sitting at the ID/EX boundary. It decodes each 32-bit RV32I instruction (plus optional RV32M) into control signals and holds them in an output register. The register supports stall, flush and a valid/ready handshake toward fetch. A small state machine holds issue for multi-cycle multiply/divide operations.

---
 rtl/control_pipe_if.sv | 40 ++++
 rtl/control_pipe.sv | 178 +++++++++++++++++
 tb/tb_control_pipe.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/control_pipe_if.sv
// ID/EX decoder bus: fetch-side handshake and stall/flush controls in,
// registered control word out.
interface control_pipe_if #(
    parameter int ALU_OP_W = 2
);
    logic [31:0]         instruction_i;
    logic                valid_i;
    logic                ready_o;
    logic                stall_i;
    logic                flush_i;
    logic                valid_o;
    logic                alusrc_o;
    logic                mem_to_reg_o;
    logic                reg_write_o;
    logic                reg_dest_o;
    logic                mem_read_o;
    logic                mem_write_o;
    logic                branch_o;
    logic                jump_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic                md_o;
    logic                md_busy_o;
    logic                illegal_o;

    // fetch / hazard side
    modport master (
        output instruction_i, valid_i, stall_i, flush_i,
        input  ready_o, valid_o, alusrc_o, mem_to_reg_o, reg_write_o, reg_dest_o,
               mem_read_o, mem_write_o, branch_o, jump_o, alu_op_o, md_o,
               md_busy_o, illegal_o
    );

    // decoder side
    modport slave (
        input  instruction_i, valid_i, stall_i, flush_i,
        output ready_o, valid_o, alusrc_o, mem_to_reg_o, reg_write_o, reg_dest_o,
               mem_read_o, mem_write_o, branch_o, jump_o, alu_op_o, md_o,
               md_busy_o, illegal_o
    );
endinterface

// File: rtl/control_pipe.sv
// Registered RV32I(+M) main decoder at the ID/EX boundary. Holds its output
// on stall, bubbles on flush, and parks multiply/divide ops in BUSY for
// MD_LATENCY-1 cycles before issuing them.
module control_pipe #(
    parameter int ALU_OP_W   = 2,
    parameter bit EN_M       = 1'b1,
    parameter int MD_LATENCY = 4
) (
    input logic           clk_i,
    input logic           rst_i,
    control_pipe_if.slave bus
);

    typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

    typedef struct packed {
        logic       alusrc;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
        logic       md;
        logic       illegal;
    } ctrl_t;

    // count holds MD_LATENCY-2 down to 0
    localparam int CNT_W    = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
    localparam int CNT_INIT = (MD_LATENCY > 1) ? MD_LATENCY - 2 : 0;
    localparam bit MD_MULTI = (MD_LATENCY > 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vld_q, vld_d;
    ctrl_t              ctrl_q, ctrl_d;
    ctrl_t              held_q, held_d;
    ctrl_t              dec;
    logic               ready;
    logic               accept;

    function automatic ctrl_t decode(input logic [6:0] opcode, input logic [6:0] funct7);
        ctrl_t c;
        c = '0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000001 && !EN_M) begin
                    c.illegal = 1'b1;
                end else begin
                    c.reg_write = 1'b1;
                    c.alu_op    = 2'd2;
                    c.md        = (funct7 == 7'b0000001);
                end
            end
            7'b0010011: begin
                c.reg_write = 1'b1;
                c.alusrc    = 1'b1;
                c.alu_op    = 2'd2;
            end
            7'b0000011: begin
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.alusrc     = 1'b1;
            end
            7'b0100011: begin
                c.mem_write = 1'b1;
                c.alusrc    = 1'b1;
            end
            7'b1100011: begin
                c.branch = 1'b1;
                c.alu_op = 2'd1;
            end
            7'b1101111: begin
                c.jump      = 1'b1;
                c.reg_write = 1'b1;
                c.reg_dest  = 1'b1;
            end
            7'b1100111: begin
                c.jump      = 1'b1;
                c.reg_write = 1'b1;
                c.reg_dest  = 1'b1;
                c.alusrc    = 1'b1;
            end
            7'b0110111: begin
                c.reg_write = 1'b1;
                c.alusrc    = 1'b1;
                c.alu_op    = 2'd3;
            end
            7'b0010111: begin
                c.reg_write = 1'b1;
                c.alusrc    = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // ready depends only on state and stall, never on valid_i
    assign ready  = (state_q == RUN) && !bus.stall_i;
    assign accept = bus.valid_i && ready;
    assign dec    = decode(bus.instruction_i[6:0], bus.instruction_i[31:25]);

    // next-state: flush beats stall beats accept/issue
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        ctrl_d  = ctrl_q;
        held_d  = held_q;
        if (bus.flush_i) begin
            state_d = RUN;
            cnt_d   = '0;
            vld_d   = 1'b0;
            ctrl_d  = '0;
        end else if (state_q == RUN) begin
            if (bus.stall_i) begin
                // hold everything
            end else if (accept && dec.md && MD_MULTI) begin
                state_d = BUSY;
                held_d  = dec;
                cnt_d   = CNT_W'(CNT_INIT);
                vld_d   = 1'b0;
                ctrl_d  = '0;
            end else if (accept) begin
                vld_d  = 1'b1;
                ctrl_d = dec;
            end else begin
                vld_d  = 1'b0;
                ctrl_d = '0;
            end
        end else begin
            // BUSY: the countdown ignores stall; only the final issue waits on it
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else if (!bus.stall_i) begin
                state_d = RUN;
                vld_d   = 1'b1;
                ctrl_d  = held_q;
            end
        end
    end

    // state, counter, held MD word and output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            ctrl_q  <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            ctrl_q  <= ctrl_d;
            held_q  <= held_d;
        end
    end

    assign bus.ready_o      = ready;
    assign bus.valid_o      = vld_q;
    assign bus.alusrc_o     = ctrl_q.alusrc;
    assign bus.mem_to_reg_o = ctrl_q.mem_to_reg;
    assign bus.reg_write_o  = ctrl_q.reg_write;
    assign bus.reg_dest_o   = ctrl_q.reg_dest;
    assign bus.mem_read_o   = ctrl_q.mem_read;
    assign bus.mem_write_o  = ctrl_q.mem_write;
    assign bus.branch_o     = ctrl_q.branch;
    assign bus.jump_o       = ctrl_q.jump;
    assign bus.alu_op_o     = ALU_OP_W'(ctrl_q.alu_op);
    assign bus.md_o         = ctrl_q.md;
    assign bus.illegal_o    = ctrl_q.illegal;
    assign bus.md_busy_o    = (state_q == BUSY);

endmodule

// File: tb/tb_control_pipe.sv
// Directed-vector bench for control_pipe: one EN_M=1/MD_LATENCY=4 instance
// and one EN_M=0 instance driven by the same stimulus.
module tb_control_pipe;

    localparam int W = 3;

    // observation vector bit positions
    localparam logic [15:0] HI  = 16'h8000; // alu_op upper bit
    localparam logic [15:0] V   = 16'h4000;
    localparam logic [15:0] AS  = 16'h2000;
    localparam logic [15:0] M2R = 16'h1000;
    localparam logic [15:0] RW  = 16'h0800;
    localparam logic [15:0] RD  = 16'h0400;
    localparam logic [15:0] MR  = 16'h0200;
    localparam logic [15:0] MW  = 16'h0100;
    localparam logic [15:0] BR  = 16'h0080;
    localparam logic [15:0] J   = 16'h0040;
    localparam logic [15:0] OP1 = 16'h0010;
    localparam logic [15:0] OP2 = 16'h0020;
    localparam logic [15:0] OP3 = 16'h0030;
    localparam logic [15:0] MD  = 16'h0008;
    localparam logic [15:0] BSY = 16'h0004;
    localparam logic [15:0] ILL = 16'h0002;
    localparam logic [15:0] RDY = 16'h0001;

    localparam logic [31:0] I_LW   = 32'h00012083;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_MUL  = 32'h02208033;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        vin = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    control_pipe_if #(.ALU_OP_W(W)) if_m ();
    control_pipe_if #(.ALU_OP_W(W)) if_n ();

    assign if_m.instruction_i = instr;
    assign if_m.valid_i       = vin;
    assign if_m.stall_i       = stall;
    assign if_m.flush_i       = flush;
    assign if_n.instruction_i = instr;
    assign if_n.valid_i       = vin;
    assign if_n.stall_i       = stall;
    assign if_n.flush_i       = flush;

    control_pipe #(.ALU_OP_W(W), .EN_M(1'b1), .MD_LATENCY(4)) dut_m (
        .clk_i(clk), .rst_i(rst), .bus(if_m.slave));
    control_pipe #(.ALU_OP_W(W), .EN_M(1'b0), .MD_LATENCY(4)) dut_n (
        .clk_i(clk), .rst_i(rst), .bus(if_n.slave));

    function automatic logic [15:0] obs_m();
        return {if_m.alu_op_o[2], if_m.valid_o, if_m.alusrc_o, if_m.mem_to_reg_o,
                if_m.reg_write_o, if_m.reg_dest_o, if_m.mem_read_o, if_m.mem_write_o,
                if_m.branch_o, if_m.jump_o, if_m.alu_op_o[1:0], if_m.md_o,
                if_m.md_busy_o, if_m.illegal_o, if_m.ready_o};
    endfunction

    function automatic logic [15:0] obs_n();
        return {if_n.alu_op_o[2], if_n.valid_o, if_n.alusrc_o, if_n.mem_to_reg_o,
                if_n.reg_write_o, if_n.reg_dest_o, if_n.mem_read_o, if_n.mem_write_o,
                if_n.branch_o, if_n.jump_o, if_n.alu_op_o[1:0], if_n.md_o,
                if_n.md_busy_o, if_n.illegal_o, if_n.ready_o};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one rising edge, then settle before sampling / driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tbl_i [8];
    logic [15:0] tbl_e [8];

    initial begin
        tbl_i[0] = I_LW;          tbl_e[0] = V|AS|M2R|RW|MR|RDY;
        tbl_i[1] = I_JAL;         tbl_e[1] = V|J|RW|RD|RDY;
        tbl_i[2] = I_BEQ;         tbl_e[2] = V|BR|OP1|RDY;
        tbl_i[3] = 32'h00000000;  tbl_e[3] = V|ILL|RDY;
        tbl_i[4] = 32'h002080B3;  tbl_e[4] = V|RW|OP2|RDY;      // add
        tbl_i[5] = 32'h00108093;  tbl_e[5] = V|RW|AS|OP2|RDY;   // addi
        tbl_i[6] = 32'h000010B7;  tbl_e[6] = V|RW|AS|OP3|RDY;   // lui
        tbl_i[7] = 32'h00112023;  tbl_e[7] = V|MW|AS|RDY;       // sw

        repeat (2) step();
        chk("reset_m", obs_m(), RDY);
        chk("reset_n", obs_n(), RDY);
        rst = 1'b0;

        // back-to-back decode table (lw, jal then beq, illegal, ...)
        vin = 1'b1;
        for (int k = 0; k < 8; k++) begin
            instr = tbl_i[k];
            step();
            chk($sformatf("dec%0d", k), obs_m(), tbl_e[k]);
        end
        instr = 32'h00001097; step(); chk("auipc", obs_m(), V|RW|AS|RDY);
        instr = 32'h000080E7; step(); chk("jalr",  obs_m(), V|J|RW|RD|AS|RDY);

        // no valid -> bubble
        vin = 1'b0;
        step();
        chk("bubble", obs_m(), RDY);

        // mul: illegal without M, 4-cycle MD with M
        vin = 1'b1; instr = I_MUL;
        step();
        chk("mul_n_illegal", obs_n(), V|ILL|RDY);
        chk("md_c1", obs_m(), BSY);
        vin = 1'b0;
        step(); chk("md_c2", obs_m(), BSY);
        step(); chk("md_c3", obs_m(), BSY);
        step(); chk("md_issue", obs_m(), V|RW|MD|OP2|RDY);
        step(); chk("md_after", obs_m(), RDY);

        // mul with stall over the last countdown edges: issue slips by 2
        vin = 1'b1; instr = I_MUL;
        step(); chk("mds_c1", obs_m(), BSY);
        vin = 1'b0;
        step(); chk("mds_c2", obs_m(), BSY);
        stall = 1'b1;
        step(); chk("mds_c3", obs_m(), BSY);
        step(); chk("mds_c4", obs_m(), BSY);
        step(); chk("mds_c5", obs_m(), BSY);
        stall = 1'b0;
        chk("mds_c5_rdy", obs_m(), BSY);
        step(); chk("mds_issue", obs_m(), V|RW|MD|OP2|RDY);

        // load then a 3-cycle stall with a jal waiting
        vin = 1'b1; instr = I_LW;
        step(); chk("ld", obs_m(), V|AS|M2R|RW|MR|RDY);
        instr = I_JAL; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ld_hold%0d", k), obs_m(), V|AS|M2R|RW|MR);
        end
        stall = 1'b0;
        step(); chk("ld_release", obs_m(), V|J|RW|RD|RDY);

        // flush together with stall
        instr = I_LW; stall = 1'b1; flush = 1'b1;
        step(); chk("flush_stall", obs_m(), 16'h0000);
        // flush in RUN with an incoming instruction: ready but not captured
        stall = 1'b0;
        step(); chk("flush_run", obs_m(), RDY);
        flush = 1'b0;

        // flush during BUSY
        instr = I_MUL;
        step(); chk("fb_busy", obs_m(), BSY);
        vin = 1'b0; flush = 1'b1;
        step(); chk("fb_flush", obs_m(), RDY);
        flush = 1'b0;
        step(); chk("fb_idle", obs_m(), RDY);

        // asynchronous reset mid-BUSY
        vin = 1'b1;
        step(); chk("ar_busy", obs_m(), BSY);
        vin = 1'b0;
        step(); chk("ar_busy2", obs_m(), BSY);
        #2 rst = 1'b1;
        #1 chk("ar_async", obs_m(), RDY);
        step();
        rst = 1'b0;
        step(); chk("ar_post", obs_m(), RDY);
        vin = 1'b1; instr = I_BEQ;
        step(); chk("ar_accept", obs_m(), V|BR|OP1|RDY);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // global time bound
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
